// File: rtl/conv2d_seq_engine_if.sv
// Handshake and data bundle of conv2d_seq_engine: start/busy/done plus the
// flattened image, kernel and result vectors (row-major, element 0 in the LSBs).
interface conv2d_seq_engine_if #(
    parameter int DW  = 8,
    parameter int IMG = 4,
    parameter int KER = 3
);
    localparam int OUT = IMG - KER + 1;

    logic                    start;
    logic [IMG*IMG*DW-1:0]   img_i;
    logic [KER*KER*DW-1:0]   ker_i;
    logic                    busy;
    logic                    done;
    logic [OUT*OUT*DW-1:0]   res_o;

    modport master (output start, img_i, ker_i, input busy, done, res_o);
    modport slave  (input start, img_i, ker_i, output busy, done, res_o);
endinterface

// File: rtl/conv2d_seq_engine.sv
// Sequential 2-D convolution: one MAC time-multiplexed over all output pixels.
// Define CONV_SATURATE_EN to saturate results at 2^DW-1 instead of truncating.
module conv2d_seq_engine #(
    parameter int DW   = 8,
    parameter int IMG  = 4,
    parameter int KER  = 3,
    parameter int ACCW = 20
) (
    input  logic               clk,
    input  logic               rst,
    conv2d_seq_engine_if.slave bus
);
    localparam int OUT = IMG - KER + 1;
    localparam int KW  = (KER > 1) ? $clog2(KER) : 1;
    localparam int OW  = (OUT > 1) ? $clog2(OUT) : 1;
    localparam int RW  = (IMG > 1) ? $clog2(IMG) : 1;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_STORE, S_DONE} state_t;

    state_t          r_state;
    logic [KW-1:0]   r_u, r_v;
    logic [OW-1:0]   r_i, r_j;
    logic [ACCW-1:0] r_acc;
    logic            r_busy, r_done;
    logic [DW-1:0]   r_img [IMG][IMG];
    logic [DW-1:0]   r_ker [KER][KER];
    logic [DW-1:0]   r_res [OUT][OUT];

    logic            w_accept;
    logic [RW-1:0]   w_row, w_col;
    logic [KW-1:0]   w_ku, w_kv;
    logic [DW-1:0]   w_pix, w_wgt;
    logic [2*DW-1:0] w_prod;
    logic [DW-1:0]   w_red;

    assign w_accept = (r_state == S_IDLE) && bus.start;

    // Image tap (i+u, j+v) meets the flipped kernel tap (KER-1-u, KER-1-v).
    assign w_row  = RW'(r_i) + RW'(r_u);
    assign w_col  = RW'(r_j) + RW'(r_v);
    assign w_ku   = KW'(KER - 1) - r_u;
    assign w_kv   = KW'(KER - 1) - r_v;
    assign w_pix  = r_img[w_row][w_col];
    assign w_wgt  = r_ker[w_ku][w_kv];
    assign w_prod = {{DW{1'b0}}, w_pix} * {{DW{1'b0}}, w_wgt};

`ifdef CONV_SATURATE_EN
    assign w_red = (r_acc > ACCW'({DW{1'b1}})) ? {DW{1'b1}} : r_acc[DW-1:0];
`else
    assign w_red = r_acc[DW-1:0];
`endif

    assign bus.busy = r_busy;
    assign bus.done = r_done;

    always_comb begin
        for (int i = 0; i < OUT; i++)
            for (int j = 0; j < OUT; j++)
                bus.res_o[(i*OUT+j)*DW +: DW] = r_res[i][j];
    end

    // NOTE: operand copies carry no reset; they are always reloaded at accept before any use.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int r = 0; r < IMG; r++)
                for (int c = 0; c < IMG; c++)
                    r_img[r][c] <= bus.img_i[(r*IMG+c)*DW +: DW];
            for (int r = 0; r < KER; r++)
                for (int c = 0; c < KER; c++)
                    r_ker[r][c] <= bus.ker_i[(r*KER+c)*DW +: DW];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_acc   <= '0;
            r_u     <= '0;
            r_v     <= '0;
            r_i     <= '0;
            r_j     <= '0;
            for (int i = 0; i < OUT; i++)
                for (int j = 0; j < OUT; j++)
                    r_res[i][j] <= '0;
        end else begin
            // NOTE: a non-blocking default makes done a single-cycle pulse; only DONE overrides it.
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_acc   <= '0;
                        r_u     <= '0;
                        r_v     <= '0;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_MAC;
                    end
                end
                S_MAC: begin
                    r_acc <= (r_u == '0 && r_v == '0) ? ACCW'(w_prod) : r_acc + ACCW'(w_prod);
                    if (r_v == KW'(KER - 1)) begin
                        r_v <= '0;
                        if (r_u == KW'(KER - 1)) begin
                            r_u     <= '0;
                            r_state <= S_STORE;
                        end else begin
                            r_u <= r_u + KW'(1);
                        end
                    end else begin
                        r_v <= r_v + KW'(1);
                    end
                end
                S_STORE: begin
                    r_res[r_i][r_j] <= w_red;
                    if (r_j == OW'(OUT - 1)) begin
                        r_j <= '0;
                        if (r_i == OW'(OUT - 1)) begin
                            r_i     <= '0;
                            r_state <= S_DONE;
                        end else begin
                            r_i     <= r_i + OW'(1);
                            r_state <= S_MAC;
                        end
                    end else begin
                        r_j     <= r_j + OW'(1);
                        r_state <= S_MAC;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv2d_seq_engine.sv
// Directed and randomized bench for conv2d_seq_engine (4x4/3x3 and 5x5/5x5 instances).
module tb_conv2d_seq_engine;
    localparam int DW = 8, IMG = 4, KER = 3, OUT = 2;
    localparam int LAT  = OUT*OUT*(KER*KER+1) + 1;
    localparam int LAT2 = 5*5 + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    conv2d_seq_engine_if #(.DW(DW), .IMG(IMG), .KER(KER)) bus ();
    conv2d_seq_engine_if #(.DW(8),  .IMG(5),   .KER(5))   bus2 ();

    conv2d_seq_engine #(.DW(DW), .IMG(IMG), .KER(KER), .ACCW(20)) dut  (.clk(clk), .rst(rst), .bus(bus));
    conv2d_seq_engine #(.DW(8),  .IMG(5),   .KER(5),   .ACCW(21)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: direct definition of true convolution on byte-packed vectors.
    function automatic int conv_pix(input logic [1023:0] img, input logic [1023:0] ker,
                                    input int n, input int k, input int i, input int j);
        int s = 0;
        for (int u = 0; u < k; u++)
            for (int v = 0; v < k; v++)
                s += int'(img[((i+u)*n + j+v)*8 +: 8]) * int'(ker[((k-1-u)*k + (k-1-v))*8 +: 8]);
        return s;
    endfunction

    function automatic int reduce(input int s);
`ifdef CONV_SATURATE_EN
        return (s > 255) ? 255 : s;
`else
        return s % 256;
`endif
    endfunction

    task automatic run_job(input logic [127:0] img, input logic [71:0] ker,
                           input int ra, input int rb, input int ch, input logic [127:0] alt,
                           input int rst_at, input string tag);
        int n_done = 0;
        int dones  = 0;
        @(negedge clk);
        bus.img_i = img;
        bus.ker_i = ker;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        check({tag, "_busy_rise"}, bus.busy, 1);
        for (int n = 1; n <= LAT + 19; n++) begin
            @(negedge clk);
            bus.start = (n == ra || n == rb);
            if (n == ch) bus.img_i = alt;
            if (rst_at > 0 && n == rst_at) begin
                rst = 1'b1;
                #1;
                check({tag, "_rst_res"},  bus.res_o, 0);
                check({tag, "_rst_busy"}, bus.busy, 0);
            end
            if (rst_at > 0 && n == rst_at + 1) rst = 1'b0;
            @(posedge clk);
            #1;
            if (rst_at <= 0 && n == LAT - 1) check({tag, "_busy_hold"}, bus.busy, 1);
            if (bus.done) begin
                dones++;
                if (n_done == 0) n_done = n;
            end
        end
        bus.start = 1'b0;
        check({tag, "_busy_end"}, bus.busy, 0);
        if (rst_at > 0) begin
            check({tag, "_no_done"}, dones, 0);
        end else begin
            check({tag, "_latency"}, n_done, LAT);
            check({tag, "_done_cnt"}, dones, 1);
            for (int i = 0; i < OUT; i++)
                for (int j = 0; j < OUT; j++)
                    check($sformatf("%s_res%0d%0d", tag, i, j), bus.res_o[(i*OUT+j)*8 +: 8],
                          reduce(conv_pix(img, ker, IMG, KER, i, j)));
        end
    endtask

    task automatic run_small(input logic [199:0] img, input logic [199:0] ker, input string tag);
        int n_done = 0;
        @(negedge clk);
        bus2.img_i = img;
        bus2.ker_i = ker;
        bus2.start = 1'b1;
        @(posedge clk);
        #1 bus2.start = 1'b0;
        for (int n = 1; n <= LAT2 + 10 && n_done == 0; n++) begin
            @(posedge clk);
            #1;
            if (bus2.done) n_done = n;
        end
        check({tag, "_latency"}, n_done, LAT2);
        check({tag, "_res"}, bus2.res_o, reduce(conv_pix(img, ker, 5, 5, 0, 0)));
    endtask

    logic [127:0] img, alt;
    logic [71:0]  ker;
    logic [199:0] img5, ker5;

    initial begin
        bus.start  = 1'b0; bus.img_i  = '0; bus.ker_i  = '0;
        bus2.start = 1'b0; bus2.img_i = '0; bus2.ker_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_res",  bus.res_o, 0);
        rst = 1'b0;

        // All ones: every pixel sums nine products of 1.
        img = {16{8'd1}};
        ker = {9{8'd1}};
        run_job(img, ker, -1, -1, -1, img, -1, "ones");
        check("ones_const", bus.res_o, {4{8'd9}});

        // Ramp image, single kernel tap at (0,0): flip selects img(i+2, j+2).
        for (int k = 0; k < 16; k++) img[k*8 +: 8] = 8'(k);
        ker = 72'd1;
        run_job(img, ker, -1, -1, -1, img, -1, "ramp");
        check("ramp_const", bus.res_o, {8'd15, 8'd14, 8'd11, 8'd10});

        // Full-scale operands: accumulator reaches 9*255*255.
        img = {16{8'hFF}};
        ker = {9{8'hFF}};
        run_job(img, ker, -1, -1, -1, img, -1, "max");
`ifdef CONV_SATURATE_EN
        check("max_const", bus.res_o, {4{8'd255}});
`else
        check("max_const", bus.res_o, {4{8'd9}});
`endif

        // Restart attempts mid-job and at cycle 40, image changed after latching.
        for (int k = 0; k < 16; k++) begin img[k*8 +: 8] = 8'($urandom); alt[k*8 +: 8] = 8'($urandom); end
        for (int k = 0; k < 9; k++) ker[k*8 +: 8] = 8'($urandom_range(0, 15));
        run_job(img, ker, 5, 40, 3, alt, -1, "ignore");

        // Reset at cycle 20 aborts the job; a fresh job then runs normally.
        run_job(alt, ker, -1, -1, -1, alt, 20, "abort");
        run_job(img, ker, -1, -1, -1, img, -1, "after_rst");

        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < 16; k++) img[k*8 +: 8] = 8'($urandom);
            for (int k = 0; k < 9; k++)  ker[k*8 +: 8] = 8'($urandom);
            run_job(img, ker, -1, -1, -1, img, -1, $sformatf("rand%0d", t));
        end

        // KER == IMG: one output pixel.
        img5 = {25{8'd1}};
        ker5 = {25{8'd1}};
        run_small(img5, ker5, "k5_ones");
        check("k5_const", bus2.res_o, 8'd25);
        for (int k = 0; k < 25; k++) begin img5[k*8 +: 8] = 8'($urandom_range(0, 7)); ker5[k*8 +: 8] = 8'($urandom_range(0, 3)); end
        run_small(img5, ker5, "k5_rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/conv2d_seq_engine.md
Name: conv2d_seq_engine

Overview:
- Parametrised sequential 2-D convolution engine: one multiply-accumulate unit, time-multiplexed over every output pixel.
- Convolves an IMG x IMG unsigned image with a KER x KER kernel. The kernel is flipped (true convolution), giving an OUT x OUT result, where OUT = IMG-KER+1.
- Sits between the image/weight buffers and the pooling/activation stage.
- Adds a start/busy/done handshake, input latching and a configurable accumulator width.

Parameters:
- DW, 8, data width of image, kernel and result elements (unsigned).
- IMG, 4, image side length; must be >= KER.
- KER, 3, kernel side length; must be >= 1.
- ACCW, 20, accumulator width; must be >= 2*DW + clog2(KER*KER).
- Derived localparam OUT = IMG-KER+1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request one convolution; sampled only in IDLE.
- img_i  in  IMG*IMG*DW  image; element (r,c) at bits [(r*IMG+c)*DW +: DW], row-major, r,c from 0.
- ker_i  in  KER*KER*DW  kernel; same packing as img_i.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when all results are written.
- res_o  out  OUT*OUT*DW  results; element (i,j) at bits [(i*OUT+j)*DW +: DW].

Behaviour:
- Reset (asynchronous): state=IDLE; busy=0; done=0; res_o=0; accumulator and all counters 0.
- Function: res(i,j) = sum over u,v in [0,KER) of img(i+u, j+v) * ker(KER-1-u, KER-1-v).
- Products are DW x DW -> 2*DW bits, zero-extended into the ACCW-bit accumulator.

State machine:
- IDLE: start=1 latches img_i and ker_i into internal registers, clears the accumulator and all counters, then moves to MAC. Inputs may change freely after that cycle.
- MAC: one product per cycle, KER*KER cycles per output pixel.
  - Kernel column index v is innermost, then row u.
  - The first product of each pixel loads the accumulator; later products add to it.
  - After u=v=KER-1, go to STORE.
- STORE: write the reduced accumulator into res(i,j); j increments and wraps to 0, then i increments.
  - Go to MAC if pixels remain, else go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, return to IDLE.

Timing and registers:
- Latency: done is high exactly OUT*OUT*(KER*KER+1)+1 cycles after the start-accept edge. Defaults: 4*10+1 = 41.
- A new start can be accepted on the cycle after the done pulse.
- res_o elements update only in their STORE cycle. Elements not yet rewritten hold their previous values; done marks a fully consistent result set.
- Result reduction: low DW bits of the accumulator (truncation), unless the optional feature is enabled.

Boundary conditions:
- start while busy or in DONE: ignored; no restart, no effect on the current job.
- rst mid-operation: immediate return to IDLE, outputs cleared, no done pulse.
- KER=IMG: OUT=1, a single pixel; latency KER*KER+2.
- KER=1: plain per-pixel scaling; latency 2*IMG*IMG+1.
- Counters are sized by clog2 of their ranges and never exceed them.

Optional Feature:
- Macro: CONV_SATURATE_EN.
- Defined: in STORE, an accumulator value above 2^DW-1 writes 2^DW-1 (all ones); otherwise the value is written unchanged.
- Undefined: truncation to the low DW bits.
- Latency and handshake are identical in both builds.

Test Plan:
- Defaults, all image and kernel elements 1, pulse start -> busy high next cycle; done at cycle 41; all four results = 9.
- Image img(r,c)=r*4+c, kernel with only ker(0,0)=1 -> due to the flip, res(i,j)=img(i+2,j+2): results 10,11,14,15.
- All elements 255 -> accumulator 585225. Without CONV_SATURATE_EN every result = 9 (585225 mod 256); with it every result = 255.
- Start pulsed again at cycles 5 and 40, and img_i changed at cycle 3 -> single done at cycle 41; results reflect the image latched at the start cycle.
- rst asserted at cycle 20 -> res_o=0, busy=0, no done pulse. A fresh start afterwards completes normally in 41 cycles.
- IMG=5, KER=5, all ones -> single result 25 (truncated, fits in 8 bits); done at cycle 27.
